// File: rtl/dearv_pkg.sv
// Purpose: shared encodings for the dmem arbiter (FSM states, owner codes, size codes, rw polarity).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dearv_pkg;

    // Ownership FSM. The encoding is chosen so that the owner code equals the state value.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b01;
    localparam logic [1:0] OWNER_M1   = 2'b10;

    // Access size codes carried on m*_word / mem_word (decoded by dmem, not here).
    localparam logic [1:0] WORD_BYTE  = 2'b00;
    localparam logic [1:0] WORD_HALF  = 2'b01;
    localparam logic [1:0] WORD_WORD  = 2'b10;
    localparam logic [1:0] WORD_DWORD = 2'b11;

    localparam logic RW_WRITE = 1'b1;

    // Master select used for pick/last: 0 = m0, 1 = m1.
    localparam logic SEL_M0 = 1'b0;
    localparam logic SEL_M1 = 1'b1;

    function automatic logic [1:0] owner_of(arb_state_t s);
        case (s)
            OWN0:    owner_of = OWNER_M0;
            OWN1:    owner_of = OWNER_M1;
            default: owner_of = OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arb_rr.sv
// Purpose: 2-way round-robin picker; on a tie the master that was not served last wins.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on pick/valid.
//
// Ports: req0/req1 - requests, last - last served master (SEL_M0/SEL_M1),
//        pick - chosen master (SEL_M0/SEL_M1), valid - at least one request present.
module dmem_arb_rr
    import dearv_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick,
    output logic valid
);

    always_comb begin
        valid = req0 | req1;
        if (req0 && req1) begin
            pick = (last == SEL_M0) ? SEL_M1 : SEL_M0;
        end else begin
            pick = req1 ? SEL_M1 : SEL_M0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose: shares the single dmem port between m0 (CPU data path) and m1 (loader/DMA/debug), round-robin with optional lock.
// Latency: request seen in IDLE is acked the next cycle; while a master owns the port its requests are acked the same cycle.
// Backpressure: a request is held with its fields until m*_ack; a non-owner simply waits (ack stays 0).
//
// Ports: clk, rst (async, active low); m0_*/m1_* request channels (req, lock, addr, rw, word, wdata -> ack, rdata);
//        mem_* dmem port (sel, addr, rw, word, wdata out; rdata in, combinational); owner (00 none/01 m0/10 m1);
//        lock_ovf one-cycle pulse when a lock is broken after MAX_HOLD consecutive accesses.
// Optional build macro DMEM_ARB_STATS_EN adds stats_clr input and grant_cnt0/grant_cnt1/wait_cnt1 outputs.
module dmem_arbiter
    import dearv_pkg::*;
#(
    parameter int AW       = 12,
    parameter int DW       = 64,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_lock,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_rw,
    input  logic [1:0]    m0_word,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_rw,
    input  logic [1:0]    m1_word,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,

    output logic          mem_sel,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rw,
    output logic [1:0]    mem_word,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,

    output logic [1:0]    owner,
    output logic          lock_ovf
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic          stats_clr,
    output logic [31:0]   grant_cnt0,
    output logic [31:0]   grant_cnt1,
    output logic [31:0]   wait_cnt1
`endif
);

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    arb_state_t state;
    logic       last;
    logic [7:0] hold_cnt;

    logic       rr_pick;
    logic       rr_valid;

    // "x" is the current owner, "y" the other master (x defaults to m0 in IDLE, unused there).
    logic       x_req;
    logic       x_lock;
    logic       x_sel;
    logic       y_req;
    arb_state_t y_state;

    dmem_arb_rr u_rr (
        .req0  (m0_req),
        .req1  (m1_req),
        .last  (last),
        .pick  (rr_pick),
        .valid (rr_valid)
    );

    always_comb begin
        if (state == OWN1) begin
            x_req   = m1_req;
            x_lock  = m1_lock;
            x_sel   = SEL_M1;
            y_req   = m0_req;
            y_state = OWN0;
        end else begin
            x_req   = m0_req;
            x_lock  = m0_lock;
            x_sel   = SEL_M0;
            y_req   = m1_req;
            y_state = OWN1;
        end
    end

    // Port mux is combinational on the registered state, so an async reset
    // removes ack/sel/rw in the same cycle and no write can complete.
    always_comb begin
        m0_ack    = (state == OWN0) && m0_req;
        m1_ack    = (state == OWN1) && m1_req;
        mem_sel   = m0_ack | m1_ack;
        mem_addr  = '0;
        mem_word  = '0;
        mem_wdata = '0;
        mem_rw    = 1'b0;
        if (state == OWN0) begin
            mem_addr  = m0_addr;
            mem_word  = m0_word;
            mem_wdata = m0_wdata;
            mem_rw    = m0_ack && (m0_rw == RW_WRITE);
        end else if (state == OWN1) begin
            mem_addr  = m1_addr;
            mem_word  = m1_word;
            mem_wdata = m1_wdata;
            mem_rw    = m1_ack && (m1_rw == RW_WRITE);
        end
        m0_rdata = m0_ack ? mem_rdata : '0;
        m1_rdata = m1_ack ? mem_rdata : '0;
    end

    assign owner = owner_of(state);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last     <= SEL_M1;      // m0 wins the first tie
            hold_cnt <= '0;
            lock_ovf <= 1'b0;
        end else begin
            lock_ovf <= 1'b0;
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (rr_valid) begin
                        state <= (rr_pick == SEL_M1) ? OWN1 : OWN0;
                    end
                end
                OWN0, OWN1: begin
                    if (!x_req) begin
                        // Owner did not use its grant: hand over or fall back to IDLE.
                        hold_cnt <= '0;
                        state    <= y_req ? y_state : IDLE;
                    end else begin
                        last <= x_sel;
                        if (!y_req) begin
                            hold_cnt <= '0;
                        end else if (!x_lock) begin
                            hold_cnt <= '0;
                            state    <= y_state;
                        end else if (hold_cnt >= HOLD_LIM) begin
                            // Lock held too long against a waiting master: force the switch.
                            hold_cnt <= '0;
                            state    <= y_state;
                            lock_ovf <= 1'b1;
                        end else if (hold_cnt != 8'hFF) begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            wait_cnt1  <= '0;
        end else if (stats_clr) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            wait_cnt1  <= '0;
        end else begin
            grant_cnt0 <= grant_cnt0 + 32'(m0_ack);
            grant_cnt1 <= grant_cnt1 + 32'(m1_ack);
            wait_cnt1  <= wait_cnt1 + 32'(m1_req && !m1_ack);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: self-checking bench for dmem_arbiter: directed scenarios followed by random traffic against a reference model.
// Latency: n/a.
// Backpressure: requesters hold req and fields until ack, as real masters do.
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int DW = 64;
    localparam int MH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          m0_req, m0_lock, m0_rw, m0_ack;
    logic [AW-1:0] m0_addr;
    logic [1:0]    m0_word;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_lock, m1_rw, m1_ack;
    logic [AW-1:0] m1_addr;
    logic [1:0]    m1_word;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          mem_sel, mem_rw;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_word;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0]    owner;
    logic          lock_ovf;
`ifdef DMEM_ARB_STATS_EN
    logic          stats_clr;
    logic [31:0]   grant_cnt0, grant_cnt1, wait_cnt1;
`endif

    dmem_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_rw(m0_rw),
        .m0_word(m0_word), .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_rw(m1_rw),
        .m1_word(m1_word), .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_word(mem_word),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .owner(owner), .lock_ovf(lock_ovf)
`ifdef DMEM_ARB_STATS_EN
        , .stats_clr(stats_clr), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .wait_cnt1(wait_cnt1)
`endif
    );

    // dmem stand-in: dword storage, combinational read, write on the clock edge.
    logic [DW-1:0] dmem [0:511];
    logic          clr_mem;
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 512; i++) dmem[i] <= '0;
        end else if (mem_sel && mem_rw) begin
            dmem[mem_addr[AW-1:3]] <= mem_wdata;
        end
    end
    assign mem_rdata = dmem[mem_addr[AW-1:3]];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner 0 none / 1 m0 / 2 m1, last served 0/1, consecutive-hold count.
    int            m_own, m_last, m_hold;
    bit            m_ovf;
    logic [DW-1:0] ref_mem [0:511];
    int            g0, g1, w1;
    int            hist[$];
    int            ovf_hist[$];
    logic [DW-1:0] last_rd0;
    bit            ack0_last, ack1_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_last = 1; m_hold = 0; m_ovf = 0;
        g0 = 0; g1 = 0; w1 = 0;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_lock = 0; m0_rw = 0; m0_addr = '0; m0_word = '0; m0_wdata = '0;
        m1_req = 0; m1_lock = 0; m1_rw = 0; m1_addr = '0; m1_word = '0; m1_wdata = '0;
    endtask

    // One clock: compare at the falling edge, then advance the model across the rising edge.
    task automatic tick();
        bit e0, e1, xr, xl, yr, ovf_n;
        int other;
        @(negedge clk);
        e0 = (m_own == 1) && m0_req;
        e1 = (m_own == 2) && m1_req;
        chk("owner",    64'(owner),    64'(m_own));
        chk("m0_ack",   64'(m0_ack),   64'(e0));
        chk("m1_ack",   64'(m1_ack),   64'(e1));
        chk("mem_sel",  64'(mem_sel),  64'(e0 | e1));
        chk("mem_rw",   64'(mem_rw),   64'((e0 & m0_rw) | (e1 & m1_rw)));
        chk("lock_ovf", 64'(lock_ovf), 64'(m_ovf));
        chk("mem_addr", 64'(mem_addr), (m_own == 1) ? 64'(m0_addr) : (m_own == 2) ? 64'(m1_addr) : 64'd0);
        chk("mem_word", 64'(mem_word), (m_own == 1) ? 64'(m0_word) : (m_own == 2) ? 64'(m1_word) : 64'd0);
        chk("mem_wdata", mem_wdata,    (m_own == 1) ? m0_wdata : (m_own == 2) ? m1_wdata : 64'd0);
        chk("m0_rdata", m0_rdata, e0 ? ref_mem[m0_addr[AW-1:3]] : 64'd0);
        chk("m1_rdata", m1_rdata, e1 ? ref_mem[m1_addr[AW-1:3]] : 64'd0);
        hist.push_back(m0_ack ? 1 : (m1_ack ? 2 : 0));
        ovf_hist.push_back(int'(lock_ovf));
        last_rd0  = m0_rdata;
        ack0_last = m0_ack;
        ack1_last = m1_ack;
`ifdef DMEM_ARB_STATS_EN
        if (stats_clr) begin
            g0 = 0; g1 = 0; w1 = 0;
        end else begin
            g0 += int'(e0); g1 += int'(e1); w1 += int'(m1_req && !e1);
        end
`endif
        ovf_n = 0;
        if (m_own == 0) begin
            m_hold = 0;
            if (m0_req && m1_req) m_own = (m_last == 1) ? 1 : 2;
            else if (m0_req)      m_own = 1;
            else if (m1_req)      m_own = 2;
        end else begin
            xr    = (m_own == 1) ? m0_req  : m1_req;
            xl    = (m_own == 1) ? m0_lock : m1_lock;
            yr    = (m_own == 1) ? m1_req  : m0_req;
            other = 3 - m_own;
            if (!xr) begin
                m_hold = 0;
                m_own  = yr ? other : 0;
            end else begin
                m_last = m_own - 1;
                if (!yr) m_hold = 0;
                else if (!xl) begin m_hold = 0; m_own = other; end
                else if (m_hold >= MH - 1) begin m_hold = 0; m_own = other; ovf_n = 1; end
                else m_hold = (m_hold < 255) ? m_hold + 1 : 255;
            end
        end
        @(posedge clk);
        if (e0 && m0_rw) ref_mem[m0_addr[AW-1:3]] = m0_wdata;
        if (e1 && m1_rw) ref_mem[m1_addr[AW-1:3]] = m1_wdata;
        m_ovf = ovf_n;
        #1;
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
        hist.delete();
        ovf_hist.delete();
    endtask

    initial begin
        int n_m1;
        int exp_seq[$];
        rst = 0;
        clr_mem = 1;
        idle_inputs();
`ifdef DMEM_ARB_STATS_EN
        stats_clr = 0;
`endif
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        clr_mem = 0;

        // Reset state
        chk("rst_owner",    64'(owner),     64'd0);
        chk("rst_m0_ack",   64'(m0_ack),    64'd0);
        chk("rst_m1_ack",   64'(m1_ack),    64'd0);
        chk("rst_mem_sel",  64'(mem_sel),   64'd0);
        chk("rst_mem_rw",   64'(mem_rw),    64'd0);
        chk("rst_lock_ovf", 64'(lock_ovf),  64'd0);
        chk("rst_mem_addr", 64'(mem_addr),  64'd0);
        chk("rst_mem_wdat", mem_wdata,      64'd0);
        chk("rst_m0_rdata", m0_rdata,       64'd0);
        rst = 1;

        // Single requester: write then read back through m0
        m0_req = 1; m0_rw = 1; m0_addr = 12'h010; m0_word = 2'b11; m0_wdata = 64'h1122334455667788;
        tick(); chk("wr_no_ack_n", 64'(hist[$]), 64'd0);
        tick(); chk("wr_ack_n1",   64'(hist[$]), 64'd1);
        m0_rw = 0; m0_wdata = '0;
        tick(); chk("rd_ack",  64'(hist[$]), 64'd1);
        chk("rd_data", last_rd0, 64'h1122334455667788);
        m0_req = 0;
        tick();
        n_m1 = 0;
        foreach (hist[i]) if (hist[i] == 2) n_m1++;
        chk("single_no_m1", 64'(n_m1), 64'd0);

        // Simultaneous requests after reset: m0 first, then strict alternation
        do_reset();
        m0_req = 1; m0_addr = 12'h020; m0_word = 2'b10;
        m1_req = 1; m1_addr = 12'h028; m1_word = 2'b01;
        tick();
        hist.delete();
        repeat (8) tick();
        for (int i = 0; i < 8; i++) chk("alt_seq", 64'(hist[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
        m0_req = 0; m1_req = 0;
        tick();

        // m1 locked for three accesses while m0 waits
        m1_req = 1; m1_lock = 1; m1_addr = 12'h030;
        tick();
        m0_req = 1; m0_addr = 12'h038;
        hist.delete(); ovf_hist.delete();
        tick(); tick();
        m1_lock = 0;
        tick();
        m1_req = 0;
        tick();
        exp_seq = '{2, 2, 2, 1};
        foreach (exp_seq[i]) chk("lock_seq", 64'(hist[i]), 64'(exp_seq[i]));
        foreach (ovf_hist[i]) chk("lock_no_ovf", 64'(ovf_hist[i]), 64'd0);

        // Lock overflow: m0 keeps its lock, m1 waits -> four m0 acks, pulse, m1
        m0_lock = 1; m1_req = 1; m1_addr = 12'h008;
        hist.delete(); ovf_hist.delete();
        repeat (5) tick();
        m1_req = 0;
        tick();
        exp_seq = '{1, 1, 1, 1, 2, 1};
        foreach (exp_seq[i]) chk("ovf_seq", 64'(hist[i]), 64'(exp_seq[i]));
        exp_seq = '{0, 0, 0, 0, 1, 0};
        foreach (exp_seq[i]) chk("ovf_pulse", 64'(ovf_hist[i]), 64'(exp_seq[i]));
        m0_req = 0; m0_lock = 0;
        tick();

        // Reset asserted in the middle of an acked write
        m0_req = 1; m0_rw = 1; m0_addr = 12'h010; m0_word = 2'b11; m0_wdata = 64'hDEADBEEF0BADF00D;
        tick();
        chk("pre_rst_ack", 64'(m0_ack), 64'd1);
        #1 rst = 0;
        #1;
        chk("rst_mid_ack",   64'(m0_ack),  64'd0);
        chk("rst_mid_rw",    64'(mem_rw),  64'd0);
        chk("rst_mid_sel",   64'(mem_sel), 64'd0);
        chk("rst_mid_owner", 64'(owner),   64'd0);
        model_reset();
        @(posedge clk);
        #1;
        idle_inputs();
        rst = 1;
        #1;
        chk("post_rst_idle", 64'(owner), 64'd0);
        m0_req = 1; m0_rw = 0; m0_addr = 12'h010;
        tick(); tick();
        chk("rst_no_write", last_rd0, 64'h1122334455667788);
        m0_req = 0;
        tick();

`ifdef DMEM_ARB_STATS_EN
        // Five m0 grants with three m1 stall cycles, then a clear that wins over an increment
        do_reset();
        m0_req = 1; m0_lock = 1; m0_addr = 12'h018; m1_req = 1; m1_addr = 12'h020;
        tick(); tick(); tick();
        m1_req = 0;
        tick(); tick(); tick();
        chk("st_grant0", 64'(grant_cnt0), 64'd5);
        chk("st_wait1",  64'(wait_cnt1),  64'd3);
        chk("st_grant1", 64'(grant_cnt1), 64'd0);
        stats_clr = 1;
        tick();
        stats_clr = 0;
        chk("clr_grant0", 64'(grant_cnt0), 64'd0);
        chk("clr_grant1", 64'(grant_cnt1), 64'd0);
        chk("clr_wait1",  64'(wait_cnt1),  64'd0);
        m0_req = 0; m0_lock = 0;
        tick();
`endif

        // Random traffic; each master keeps its request stable until acked
        idle_inputs();
        ack0_last = 0; ack1_last = 0;
        for (int c = 0; c < 400; c++) begin
            if (!m0_req || ack0_last) begin
                m0_req   = ($urandom_range(0, 3) != 0);
                m0_lock  = 1'($urandom_range(0, 1));
                m0_rw    = 1'($urandom_range(0, 1));
                m0_addr  = 12'($urandom_range(0, 7) * 8);
                m0_word  = 2'($urandom_range(0, 3));
                m0_wdata = {$urandom, $urandom};
            end
            if (!m1_req || ack1_last) begin
                m1_req   = ($urandom_range(0, 2) != 0);
                m1_lock  = 1'($urandom_range(0, 1));
                m1_rw    = 1'($urandom_range(0, 1));
                m1_addr  = 12'($urandom_range(0, 7) * 8);
                m1_word  = 2'($urandom_range(0, 3));
                m1_wdata = {$urandom, $urandom};
            end
            tick();
        end
        idle_inputs();
        tick(); tick();
`ifdef DMEM_ARB_STATS_EN
        chk("rnd_grant0", 64'(grant_cnt0), 64'(g0));
        chk("rnd_grant1", 64'(grant_cnt1), 64'(g1));
        chk("rnd_wait1",  64'(wait_cnt1),  64'(w1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
